tros_frame_serializer: RTL and testbench
========================================

// Module: tros_frame_serializer
// PURPOSE
//  Multi-channel successor of the single-select counter readout. Takes latched
//  cycle counts from NUM_CH frequency-measurement channels and serialises them
//  as framed, parity-protected words, MSB first, with Manchester coding
//  (bit XOR clk), on a clock supplied by the RP2040.
//  It supports single-channel requests and an auto-scan mode that sends every
//  channel back to back. It sits between the fmeasurment instances and uo_out.
// PARAMETERS
//  NUM_CH       4        number of count channels (>=1)
//  CNT_W        20       width of each cycle count
//  PREAMBLE_W   4        preamble width
//  PREAMBLE     4'b1010  preamble pattern, sent first
//  SYNC_STAGES  3        synchroniser depth for send_req and ena (>=2)
//  GAP_CYCLES   2        idle bit-times between frames in scan mode (>=1)
//  localparam CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1
//  localparam FRAME_W = PREAMBLE_W + CH_W + CNT_W + 1
// PORTS
//  clk         in   1              readout clock (RP2040-driven)
//  rst_n       in   1              asynchronous reset, active low
//  ena         in   1              design enable; async, synchronised internally
//  send_req    in   1              frame request; async, synchronised, rising-edge
//  scan_mode   in   1              0: send ch_sel only, 1: send ch 0..NUM_CH-1
//  ch_sel      in   CH_W           channel for single mode
//  counts      in   NUM_CH*CNT_W   ch k = counts[k*CNT_W +: CNT_W]; held stable by caller
//  busy        out  1              high while a frame/scan is in progress
//  frame_done  out  1              1-cycle pulse after last bit of a request
//  tx_data     out  1              NRZ serial bit (registered)
//  tx_manch    out  1              tx_data ^ clk (Manchester, combinational)
// BEHAVIOUR
//  Reset: rst_n low clears all flops immediately. busy=0, frame_done=0, tx_data=0,
//   FSM=IDLE, sync chains=0, shift reg=0.
//  Sync: send_req and ena pass through SYNC_STAGES flops each. req_rise = sync
//   MSB & ~prev (prev is one extra flop). Only a rising edge starts a request.
//   A level held high never retriggers.
//  Frame, MSB first: {PREAMBLE, ch_id[CH_W-1:0], count[CNT_W-1:0], par}.
//   par = XOR of ch_id and count bits (even parity over id+count).
//   ch_id >= NUM_CH (non-power-of-2 NUM_CH): count field forced to 0, id sent as-is.
//  FSM IDLE -> LOAD -> SHIFT -> (GAP -> LOAD ...) -> IDLE:
//   IDLE : tx_data=0, busy=0. On req_rise & ena_s, capture scan_mode into
//          scan_r and set ch_r = scan_mode ? 0 : ch_sel. Go to LOAD.
//   LOAD : 1 cycle, busy=1. At exit, shift reg <= frame(ch_r), bitcnt <= FRAME_W-1.
//          Go to SHIFT.
//   SHIFT: tx_data = shift reg MSB. Shift left one bit per cycle.
//          Exactly FRAME_W bit-times. At bitcnt==0: if scan_r & ch_r<NUM_CH-1,
//          ch_r++ and go to GAP; else go to IDLE and pulse frame_done.
//   GAP  : tx_data=0 for GAP_CYCLES cycles, then go to LOAD.
//  Latency: first preamble bit is on tx_data after the (SYNC_STAGES+2)th rising
//   clk edge, counting the first edge that samples send_req high.
//  Counts are sampled at LOAD exit. A scan frame carries that channel's value at its own LOAD.
//  Scan output is NUM_CH frames with GAP_CYCLES between each; frame_done pulses once, after the last.
//  req_rise while busy: ignored, not queued. ch_sel/scan_mode changes mid-request: ignored.
//  ena_s low in any state: next edge -> IDLE, shift reg cleared, tx_data=0.
//   No frame_done. A new request needs a fresh send_req rise after ena_s returns.
//  NUM_CH=1: scan behaves identically to single mode.
//  busy = (state != IDLE); it is high from LOAD entry to the IDLE return edge.
// TESTING (NUM_CH=4, CNT_W=20, SYNC_STAGES=3, GAP_CYCLES=2; FRAME_W=27)
//  1 Single: ch_sel=2, counts[ch2]=20'h12345, pulse send_req.
//    -> first bit after 5th edge; tx_data = 1010_10_0001_0010_0011_0100_0101_0;
//    -> frame_done pulses once; tx_manch == tx_data^clk throughout.
//  2 Parity: ch_sel=1, count=20'h00001 -> last bit 0. ch_sel=0, count=20'h00001 -> last bit 1.
//  3 Scan: scan_mode=1, counts={4'hD..} distinct per channel.
//    -> 4 frames, ids 00,01,10,11 in order, each separated by 2 zero bits.
//    -> one frame_done; busy high for 4*(1+27)+3*2 cycles.
//  4 Retrigger: hold send_req high for 100 cycles -> exactly one frame.
//    A second rise during busy -> ignored. A rise after IDLE -> new frame.
//  5 Abort: drop ena at frame bit 10 -> tx_data=0 and busy=0 within 4 cycles, no frame_done.
//    Assert rst_n low mid-scan -> all outputs 0 immediately.
//  6 Random: 200 random requests and counts vs a reference model.
//    -> bit-exact stream; busy never glitches between frames.

Source files
------------

// File: rtl/tros_frame_serializer.sv
// tros_frame_serializer
//   Serialises latched cycle counts from NUM_CH frequency channels as framed,
//   parity-protected words (MSB first) with a Manchester copy of the line.
//   Frame: {PREAMBLE, ch_id, count, par}, where par is the even parity over
//   ch_id and count. Supports single-channel requests and an auto-scan mode
//   that sends channel 0..NUM_CH-1 back to back, with GAP_CYCLES idle bits
//   between frames.
// Ports
//   clk        readout clock (RP2040-driven)
//   rst_n      asynchronous reset, active low
//   ena        design enable, asynchronous, synchronised internally
//   send_req   frame request, asynchronous; only a synchronised rising edge acts
//   scan_mode  0: send ch_sel only, 1: scan every channel
//   ch_sel     channel for single mode
//   counts     packed counts, ch k = counts[k*CNT_W +: CNT_W]
//   busy       high while a frame or scan is in progress
//   frame_done 1-cycle pulse after the last bit of a request
//   tx_data    NRZ serial bit (flop output)
//   tx_manch   tx_data ^ clk
module tros_frame_serializer #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 20,
  parameter int PREAMBLE_W  = 4,
  parameter logic [PREAMBLE_W-1:0] PREAMBLE = 4'b1010,
  parameter int SYNC_STAGES = 3,
  parameter int GAP_CYCLES  = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int FRAME_W = PREAMBLE_W + CH_W + CNT_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    send_req,
  input  logic                    scan_mode,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic [NUM_CH*CNT_W-1:0] counts,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    tx_data,
  output logic                    tx_manch
);

  localparam int BC_W  = $clog2(FRAME_W);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] req_sync, ena_sync;
  logic                   req_prev;
  logic                   req_rise, ena_s;

  logic                   scan_r;
  logic [CH_W-1:0]        ch_r;
  logic [FRAME_W-1:0]     sr_q;
  logic [BC_W-1:0]        bitcnt_q;
  logic [GAP_W-1:0]       gap_q;

  logic [CNT_W-1:0]       sel_cnt;
  logic [FRAME_W-1:0]     frame_w;

  // ---------------------------------------------------------------- sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= '0;
      ena_sync <= '0;
      req_prev <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], send_req};
      ena_sync <= {ena_sync[SYNC_STAGES-2:0], ena};
      req_prev <= req_sync[SYNC_STAGES-1];
    end
  end

  assign req_rise = req_sync[SYNC_STAGES-1] & ~req_prev;
  assign ena_s    = ena_sync[SYNC_STAGES-1];

  // ------------------------------------------------------ frame assembly
  // Ids beyond NUM_CH (non-power-of-2 channel counts) match no channel and
  // therefore carry a zero count.
  always_comb begin
    sel_cnt = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch_r == CH_W'(k)) sel_cnt = counts[k*CNT_W +: CNT_W];
    frame_w = {PREAMBLE, ch_r, sel_cnt, ^{ch_r, sel_cnt}};
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_rise) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: if (bitcnt_q == '0)
               state_d = (scan_r && ch_r < LAST_CH) ? GAP : IDLE;
      GAP:   if (gap_q == LAST_GAP) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    // Losing enable aborts from any state without a completion pulse.
    if (!ena_s) state_d = IDLE;
  end

  // ------------------------------------------------------------ datapath
  // tx_data is the shift register MSB. The register only holds non-zero data
  // during SHIFT: zeros shift in behind the frame, so after the last bit the
  // line is already 0 for GAP/IDLE/LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_r     <= 1'b0;
      ch_r       <= '0;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      gap_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!ena_s) begin
        sr_q     <= '0;
        bitcnt_q <= '0;
        gap_q    <= '0;
      end else begin
        case (state_q)
          IDLE: if (req_rise) begin
            scan_r <= scan_mode;
            ch_r   <= scan_mode ? '0 : ch_sel;
          end
          LOAD: begin
            sr_q     <= frame_w;
            bitcnt_q <= LAST_BIT;
          end
          SHIFT: begin
            sr_q     <= {sr_q[FRAME_W-2:0], 1'b0};
            bitcnt_q <= bitcnt_q - BC_W'(1);
            if (bitcnt_q == '0) begin
              gap_q <= '0;
              if (scan_r && ch_r < LAST_CH) ch_r <= ch_r + CH_W'(1);
              else                          frame_done <= 1'b1;
            end
          end
          GAP: gap_q <= gap_q + GAP_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign tx_data  = sr_q[FRAME_W-1];
  assign tx_manch = tx_data ^ clk;

endmodule

// File: tb/tb_tros_frame_serializer.sv
// Directed + random bench for tros_frame_serializer (NUM_CH=4, CNT_W=20,
// SYNC_STAGES=3, GAP_CYCLES=2, FRAME_W=27). Cycle c below means "sampled at
// the falling edge after rising edge c", edge 1 being the first edge that
// sees send_req high.
module tb_tros_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_n, ena, send_req, scan_mode;
  logic [1:0]  ch_sel;
  logic [79:0] counts;
  logic        busy, frame_done, tx_data, tx_manch;

  int n_chk = 0, n_pass = 0, manch_err = 0;
  logic r_tx [0:199];
  logic r_busy [0:199];
  logic r_fd [0:199];

  tros_frame_serializer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .send_req(send_req),
    .scan_mode(scan_mode), .ch_sel(ch_sel), .counts(counts),
    .busy(busy), .frame_done(frame_done), .tx_data(tx_data), .tx_manch(tx_manch)
  );

  always #5 clk = ~clk;

  // Manchester output checked mid-phase on both clock levels.
  always begin
    @(clk);
    #2;
    if (tx_manch !== (tx_data ^ clk)) manch_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [26:0] frame_of(input logic [1:0] ch, input logic [79:0] cv);
    logic [19:0] c;
    c = cv[ch*20 +: 20];
    return {4'b1010, ch, c, ^{ch, c}};
  endfunction

  // Issue one request and check the complete cycle-by-cycle response.
  // hold: cycle at which send_req drops; rr_at>0: extra pulse mid-request.
  task automatic run_req(input string tag, input bit scan, input logic [1:0] sel,
                         input int hold, input int rr_at,
                         output logic [26:0] w0, output int nbusy);
    int nf, len, n, busy_err, fd_err, zero_err, nfd, quiet_err, s;
    logic [26:0] w;
    logic eb, inframe;
    nf = scan ? 4 : 1;
    len = nf * 28 + (nf - 1) * 2;
    n = 4 + len + 3;
    busy_err = 0; fd_err = 0; zero_err = 0; nfd = 0; quiet_err = 0; nbusy = 0;
    w0 = '0;
    send_req = 1'b0;
    repeat (5) @(negedge clk);
    scan_mode = scan; ch_sel = sel; send_req = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      r_tx[c] = tx_data; r_busy[c] = busy; r_fd[c] = frame_done;
      if (c == hold) send_req = 1'b0;
      if (rr_at > 0 && c == rr_at) send_req = 1'b1;
      if (rr_at > 0 && c == rr_at + 2) send_req = 1'b0;
      if (c == 8) begin scan_mode = ~scan; ch_sel = ~sel; end
    end
    for (int c = 1; c <= n; c++) begin
      eb = (c >= 4 && c < 4 + len);
      if (r_busy[c] !== eb) busy_err++;
      if (r_fd[c] !== (c == 4 + len)) fd_err++;
      nbusy += int'(r_busy[c]);
      nfd += int'(r_fd[c]);
      inframe = 1'b0;
      for (int f = 0; f < nf; f++)
        if (c >= 5 + f * 30 && c < 5 + f * 30 + 27) inframe = 1'b1;
      if (!inframe && r_tx[c] !== 1'b0) zero_err++;
    end
    for (int f = 0; f < nf; f++) begin
      s = 5 + f * 30;
      for (int i = 0; i < 27; i++) w[26-i] = r_tx[s+i];
      chk($sformatf("%s_frame%0d", tag, f), 32'(w),
          32'(frame_of(scan ? 2'(f) : sel, counts)));
      if (f == 0) w0 = w;
    end
    chk({tag, "_busy_seq"}, busy_err, 0);
    chk({tag, "_fd_seq"}, fd_err, 0);
    chk({tag, "_fd_count"}, nfd, 1);
    chk({tag, "_idle_zero"}, zero_err, 0);
    repeat (10) begin
      @(negedge clk);
      if (busy || frame_done) quiet_err++;
    end
    chk({tag, "_quiet"}, quiet_err, 0);
  endtask

  initial begin
    logic [26:0] w;
    int nb, fdc, bad;
    rst_n = 1'b0; ena = 1'b1; send_req = 1'b0; scan_mode = 1'b0; ch_sel = 2'd0;
    counts = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_fd", frame_done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame, ch2 = 0x12345
    counts = {20'h0, 20'h12345, 20'h0, 20'h0};
    run_req("single", 1'b0, 2'd2, 2, 0, w, nb);
    chk("single_word", 32'(w), 32'(27'b1010_10_0001_0010_0011_0100_0101_0));
    chk("single_lat_c4", r_tx[4], 0);
    chk("single_lat_c5", r_tx[5], 1);
    chk("single_busy_len", nb, 28);

    // Parity
    counts = {20'h0, 20'h0, 20'h00001, 20'h00001};
    run_req("par1", 1'b0, 2'd1, 2, 0, w, nb);
    chk("par1_bit", w[0], 0);
    run_req("par0", 1'b0, 2'd0, 2, 0, w, nb);
    chk("par0_bit", w[0], 1);
    counts = {20'hFFFFF, 20'h0, 20'h0, 20'h0};
    run_req("ones", 1'b0, 2'd3, 1, 0, w, nb);
    chk("ones_word", 32'(w), 32'(27'b1010_11_1111_1111_1111_1111_1111_0));

    // Scan
    counts = {20'hD1234, 20'hD0123, 20'hD0012, 20'hD0001};
    run_req("scan", 1'b1, 2'd2, 2, 0, w, nb);
    chk("scan_busy_len", nb, 118);

    // Level held high: one frame only; then a rise during busy is ignored
    run_req("hold", 1'b0, 2'd3, 100, 0, w, nb);
    send_req = 1'b0;
    run_req("rr_busy", 1'b0, 2'd1, 3, 12, w, nb);
    run_req("after", 1'b0, 2'd2, 2, 0, w, nb);

    // Abort via ena at frame bit 10
    send_req = 1'b0;
    repeat (5) @(negedge clk);
    scan_mode = 1'b0; ch_sel = 2'd3; send_req = 1'b1;
    fdc = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      fdc += int'(frame_done);
      if (c == 3) send_req = 1'b0;
    end
    ena = 1'b0;
    repeat (4) begin @(negedge clk); fdc += int'(frame_done); end
    chk("abort_busy", busy, 0);
    chk("abort_tx", tx_data, 0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      fdc += int'(frame_done);
      if (busy || tx_data) bad++;
    end
    chk("abort_fd", fdc, 0);
    chk("abort_stay_idle", bad, 0);
    ena = 1'b1;
    repeat (5) @(negedge clk);
    run_req("post_abort", 1'b0, 2'd0, 2, 0, w, nb);

    // Reset mid-scan
    send_req = 1'b0;
    repeat (5) @(negedge clk);
    scan_mode = 1'b1; send_req = 1'b1;
    repeat (3) @(negedge clk);
    send_req = 1'b0;
    repeat (47) @(negedge clk);
    chk("midscan_busy_pre", busy, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tx", tx_data, 0);
    chk("rst_mid_fd", frame_done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Random requests
    for (int t = 0; t < 200; t++) begin
      logic sc;
      for (int k = 0; k < 4; k++) counts[k*20 +: 20] = 20'($urandom());
      sc = ($urandom_range(0, 3) == 0);
      run_req($sformatf("rnd%0d", t), sc, 2'($urandom()),
              int'($urandom_range(1, 4)), 0, w, nb);
    end

    chk("manchester", manch_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
